// File: rtl/alu_pkg.sv
// Shared types for seq_alu: operation codes, error codes and FSM states.
// Op 0101 (MOD) is legal only when SEQ_ALU_MOD_EN is defined.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_MUL = 4'b0010,
    OP_DIV = 4'b0100,
    OP_MOD = 4'b0101
  } op_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_INVALID = 2'b01,
    ERR_DIV0    = 2'b10,
    ERR_ILLEGAL = 2'b11
  } err_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DIV  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic logic op_is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

  function automatic logic op_legal(input logic [3:0] op);
`ifdef SEQ_ALU_MOD_EN
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) ||
           (op == OP_DIV) || (op == OP_MOD);
`else
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) ||
           (op == OP_DIV);
`endif
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Operand/result handshake bundle between an operand source and seq_alu.
interface seq_alu_if import alu_pkg::*; #(parameter int WIDTH = 8);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in1;
  logic [WIDTH-1:0]   in2;
  logic [3:0]         op;
  logic               invalid_data;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out;
  logic               zero;
  logic               error;
  err_e               err_code;

  modport master (
    output in_valid, in1, in2, op, invalid_data, out_ready,
    input  in_ready, out_valid, out, zero, error, err_code
  );

  modport slave (
    input  in_valid, in1, in2, op, invalid_data, out_ready,
    output in_ready, out_valid, out, zero, error, err_code
  );
endinterface

// File: rtl/seq_alu_div.sv
// Iterative restoring divider: one quotient bit per cycle, WIDTH cycles total.
// The first bit is resolved on the start edge; done pulses once results are final.
module seq_alu_div #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d;

  // quo holds the not-yet-consumed dividend bits above the quotient bits built so far
  function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] rem,
                                                  input logic [WIDTH-1:0] quo,
                                                  input logic [WIDTH-1:0] dvs);
    logic [WIDTH:0] trial;
    trial = {rem, quo[WIDTH-1]};
    if (trial >= {1'b0, dvs})
      return {WIDTH'(trial - {1'b0, dvs}), quo[WIDTH-2:0], 1'b1};
    return {WIDTH'(trial), quo[WIDTH-2:0], 1'b0};
  endfunction

  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start) begin
      {rem_d, quo_d} = div_step('0, dividend, divisor);
      dvs_d  = divisor;
      cnt_d  = CW'(WIDTH - 1);
      busy_d = (WIDTH > 1);
      done_d = (WIDTH == 1);
    end else if (busy_q) begin
      {rem_d, quo_d} = div_step(rem_q, quo_q, dvs_q);
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;
endmodule

// File: rtl/seq_alu.sv
// Registered, handshaked ALU: one operation in flight, multi-cycle DIV/MOD.
// Define SEQ_ALU_MOD_EN to make op 0101 (MOD) legal; otherwise it is an illegal op.
module seq_alu import alu_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  seq_alu_if.slave bus
);
  localparam int RW = 2 * WIDTH;

  state_e        state_q, state_d;
  logic [RW-1:0] out_q, out_d;
  logic          zero_q, zero_d, error_q, error_d, is_mod_q, is_mod_d;
  err_e          err_q, err_d;

  logic             in_ready, div_start, div_busy, div_done;
  logic [WIDTH-1:0] div_quo, div_rem;
  logic [RW-1:0]    a_ext, b_ext, alu_res, div_res;
  err_e             err_in;

  assign a_ext   = {{WIDTH{1'b0}}, bus.in1};
  assign b_ext   = {{WIDTH{1'b0}}, bus.in2};
  assign div_res = {{WIDTH{1'b0}}, (is_mod_q ? div_rem : div_quo)};
  assign in_ready = (state_q == ST_IDLE) && !div_busy;

  always_comb begin
    err_in = ERR_NONE;
    if (bus.invalid_data)                           err_in = ERR_INVALID;
    else if (!op_legal(bus.op))                     err_in = ERR_ILLEGAL;
    else if (op_is_div(bus.op) && bus.in2 == '0)    err_in = ERR_DIV0;
  end

  always_comb begin
    case (bus.op)
      OP_SUB:  alu_res = a_ext - b_ext;
      OP_MUL:  alu_res = a_ext * b_ext;
      default: alu_res = a_ext + b_ext;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    zero_d    = zero_q;
    error_d   = error_q;
    err_d     = err_q;
    is_mod_d  = is_mod_q;
    div_start = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.in_valid && in_ready) begin
        if (err_in != ERR_NONE) begin
          out_d   = RW'(1);
          zero_d  = 1'b0;
          error_d = 1'b1;
          err_d   = err_in;
          state_d = ST_DONE;
        end else if (op_is_div(bus.op)) begin
          div_start = 1'b1;
          is_mod_d  = (bus.op == OP_MOD);
          state_d   = ST_DIV;
        end else begin
          out_d   = alu_res;
          zero_d  = (alu_res == '0);
          error_d = 1'b0;
          err_d   = ERR_NONE;
          state_d = ST_DONE;
        end
      end
      ST_DIV: if (div_done) begin
        out_d   = div_res;
        zero_d  = (div_res == '0);
        error_d = 1'b0;
        err_d   = ERR_NONE;
        state_d = ST_DONE;
      end
      ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      out_q    <= '0;
      zero_q   <= 1'b1;
      error_q  <= 1'b0;
      err_q    <= ERR_NONE;
      is_mod_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      zero_q   <= zero_d;
      error_q  <= error_d;
      err_q    <= err_d;
      is_mod_q <= is_mod_d;
    end
  end

  seq_alu_div #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (bus.in1),
    .divisor   (bus.in2),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.out       = out_q;
  assign bus.zero      = zero_q;
  assign bus.error     = error_q;
  assign bus.err_code  = err_q;
endmodule

// File: doc/seq_alu.md
# seq_alu

Registered, handshaked successor of the combinational team ALU, parametrised in operand width. It adds valid/ready flow control, registered results, an iterative multi-cycle divider, and an error code. It sits between an operand source (register file or test driver) and a result consumer. Exactly one operation is in flight at a time.

## Interface
- `WIDTH`, default 8: operand width; results are `2*WIDTH` bits.
- `clk  in  1`: single clock; all state updates on the rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `in_valid  in  1`: operands and op are valid this cycle.
- `in_ready  out  1`: block can accept an operation.
- `in1`, `in2  in  WIDTH`: unsigned operands.
- `op  in  4`: operation code (ADD=0000, SUB=0001, MUL=0010, DIV=0100, MOD=0101).
- `invalid_data  in  1`: source flags the operands as corrupt; sampled with the operation.
- `out_valid  out  1`: result registers hold a completed result.
- `out_ready  in  1`: consumer accepts the result.
- `out  out  2*WIDTH`: result.
- `zero  out  1`: `out == 0` for the held result.
- `error  out  1`: the held result is an error result.
- `err_code  out  2`: error reason. 00 = none, 01 = invalid_data, 10 = divide by zero, 11 = illegal op.

## Operation
- States: IDLE, DIV, DONE.
- `in_ready = (state == IDLE)`. An operation is accepted on a cycle where `in_valid && in_ready`. Operands, op and `invalid_data` are captured then.
- Operands are zero-extended to `2*WIDTH` before any arithmetic.
  - SUB wraps modulo `2^(2*WIDTH)`.
  - MUL is exact.
  - DIV gives the quotient in the low `WIDTH` bits; the upper bits are 0.
  - MOD gives the remainder in the low `WIDTH` bits.
- Error priority on accept: invalid_data, then illegal op, then divide by zero (DIV/MOD with `in2 == 0`).
  - Error result: `out = 1`, `error = 1`, `zero = 0`, `err_code` set.
  - The state goes directly IDLE → DONE.
- ADD, SUB, MUL and any error: IDLE → DONE on accept; the result is registered at the same edge.
- DIV and MOD (no error): IDLE → DIV. The restoring divider runs one quotient bit per cycle for `WIDTH` cycles, then DIV → DONE with the result registered.
- DONE: `out_valid = 1`. The outputs are held stable until `out_ready`, then DONE → IDLE.
- `out_ready` asserted while not in DONE has no effect.
- Reset, at any time including mid-divide:
  - State returns to IDLE and the divider is cleared.
  - `out = 0`, `zero = 1`, `error = 0`, `err_code = 00`, `out_valid = 0`.
  - `in_ready` is 1 once reset deasserts.
- `out`, `zero`, `error` and `err_code` change only on entry to DONE or on reset.

## Timing
- ADD/SUB/MUL/error: accept at edge N gives `out_valid` at edge N (visible in cycle N+1). Latency is 1 cycle.
- DIV/MOD: accept at edge N gives `out_valid` after edge N+WIDTH. Latency is `WIDTH` cycles.
- Throughput: no back-to-back acceptance. `in_ready` is low from the accepting edge until the edge where DONE is left.
- A new operation can be accepted on the cycle after the `out_ready` handshake, at the earliest.

## Configuration
- `SEQ_ALU_MOD_EN`
  - Defined: op 0101 (MOD) is legal and returns the remainder.
  - Undefined: 0101 is an illegal op and returns the error result with `err_code = 11`. The remainder path is still computed internally but not selectable.

## Structure
- Package `alu_pkg`:
  - Op enum: `OP_ADD`, `OP_SUB`, `OP_MUL`, `OP_DIV`, `OP_MOD`.
  - Error code enum: `ERR_NONE`, `ERR_INVALID`, `ERR_DIV0`, `ERR_ILLEGAL`.
  - State enum.
- Sub-module `seq_alu_div`: `WIDTH`-parametrised iterative restoring divider with `start`, `busy`, `done`, `quotient` and `remainder`; reset uses the same asynchronous `rst`.
- The top level owns the FSM, operand capture, error decode and output registers.

## Test plan
All scenarios use `WIDTH=8`.
- Reset mid-divide: reset 3 cycles into DIV 200/7 → `out_valid=0`, `out=0`, `zero=1`, `in_ready=1` after release. The next ADD 1+1 returns 2.
- ADD 255+255 → `out=510` one cycle after accept. SUB 3−5 → `out=0xFFFE`. MUL 255×255 → `out=65025`, `zero=0`.
- DIV 200/7 → `out=28` exactly 8 cycles after accept. MOD 200/7 (`SEQ_ALU_MOD_EN` defined) → `out=4`. SUB 9−9 → `out=0`, `zero=1`.
- DIV 5/0 → `error=1`, `err_code=10`, `out=1`, latency 1. `invalid_data=1` with ADD → `err_code=01`. op=1111 → `err_code=11`. `invalid_data` together with DIV by 0 → `err_code=01`.
- Backpressure: hold `out_ready=0` for 5 cycles after MUL 12×12 → `out=144` stable, `in_ready=0`, and a new `in_valid` is ignored. Release → the handshake completes and the next op is accepted.
- Build without `SEQ_ALU_MOD_EN`: op=0101 → `error=1`, `err_code=11`, `out=1`.
